// File: rtl/serial_pattern_pkg.sv
// Shared constants, fill-state encoding and helpers for serial_pattern_detector.
package serial_pattern_pkg;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_CNT_W   = 8;

  // The fill counter runs FILLING while fewer than PAT_LEN bits have arrived, then stays ARMED.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

  // Width needed to count 0..n inclusive.
  function automatic int fill_cnt_width(input int n);
    if (n < 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/enabled_shift_reg.sv
// N-bit shift register built as a chain of enabled D stages; newest bit enters at q[0].
module enabled_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [N-1:0] q
);

  logic [N-1:0] stage_in_s;

  assign stage_in_s = {q[N-2:0], d};

  for (genvar i = 0; i < N; i++) begin : g_stage
    logic stage_q;

    // One enabled D stage: clear wins over enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= 1'b0;
      end else if (clr) begin
        stage_q <= 1'b0;
      end else if (en) begin
        stage_q <= stage_in_s[i];
      end else begin
        stage_q <= stage_q;
      end
    end

    assign q[i] = stage_q;
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts enabled bits into a history register, pulses detect on a
// pattern match once PAT_LEN bits have arrived, and keeps a saturating match count.
// Build option: define SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN to flush history and fill on every
// match so consecutive matches never share bits.
module serial_pattern_detector
  import serial_pattern_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               d,
  output logic               detect,
  output logic [CNT_W-1:0]   count,
  output logic [PAT_LEN-1:0] hist
);

  localparam int                FILL_W    = fill_cnt_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist_q;
  logic [PAT_LEN-1:0] hist_next_s;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               detect_q;
  logic               match_s;
  logic               flush_s;
  logic               shift_clr_s;
  fill_state_e        fill_state_s;

  assign hist_next_s = {hist_q[PAT_LEN-2:0], d};
  assign shift_clr_s = clr | flush_s;

  enabled_shift_reg #(
    .N(PAT_LEN)
  ) u_hist (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (shift_clr_s),
    .en   (en),
    .d    (d),
    .q    (hist_q)
  );

  // Match decode, fill advance and saturating count next-state.
  always_comb begin
    fill_state_s = FILLING;
    match_s      = 1'b0;
    fill_d       = fill_q;
    count_d      = count_q;
    flush_s      = 1'b0;

    if (fill_q == FILL_FULL) begin
      fill_state_s = ARMED;
    end else begin
      fill_state_s = FILLING;
    end

    // A match needs the shifted-in history to equal the pattern and at least PAT_LEN bits seen.
    if (en && !clr && (hist_next_s == PATTERN) && (fill_q >= FILL_ARM)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end

    case (fill_state_s)
      FILLING: fill_d = fill_q + FILL_W'(1);
      ARMED:   fill_d = fill_q;
      default: fill_d = '0;
    endcase

`ifdef SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN
    // Restart from an empty history so the next match needs PAT_LEN fresh bits.
    if (match_s) begin
      fill_d  = '0;
      flush_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
`else
    flush_s = 1'b0;
`endif

    if (match_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Fill level, detect pulse and match count; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q   <= '0;
      count_q  <= '0;
      detect_q <= 1'b0;
    end else if (clr) begin
      fill_q   <= '0;
      count_q  <= '0;
      detect_q <= 1'b0;
    end else if (en) begin
      fill_q   <= fill_d;
      count_q  <= count_d;
      detect_q <= match_s;
    end else begin
      fill_q   <= fill_q;
      count_q  <= count_q;
      detect_q <= 1'b0;
    end
  end

  assign detect = detect_q;
  assign count  = count_q;
  assign hist   = hist_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Randomized and directed bench for serial_pattern_detector. Three instances share one stimulus:
// default (1011, 8-bit count), all-zero pattern (fill guard), and 2-bit count (saturation).
module tb_serial_pattern_detector;

  logic clk, rst_n, clr, en, d;
  logic       det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [3:0] hist0, hist1, hist2;

  int checks   = 0;
  int failures = 0;

  serial_pattern_detector u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d(d),
    .detect(det0), .count(cnt0), .hist(hist0)
  );

  serial_pattern_detector #(.PATTERN(4'b0000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d(d),
    .detect(det1), .count(cnt1), .hist(hist1)
  );

  serial_pattern_detector #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d(d),
    .detect(det2), .count(cnt2), .hist(hist2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the list of enabled bits since reset/clr, plus per-instance start offset
  // (moved forward on a match in the non-overlapping build) and match count.
  bit         stream[$];
  int         start_m[3];
  int         cnt_m[3];
  bit         det_m[3];
  logic [3:0] pat_m[3];
  int         max_m[3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Last up-to-4 bits usable by instance k, oldest in the MSB, zero padded.
  function automatic logic [3:0] window(input int k);
    logic [3:0] v = 4'b0000;
    int avail = stream.size() - start_m[k];
    int n = (avail < 4) ? avail : 4;
    for (int i = stream.size() - n; i < stream.size(); i++) v = {v[2:0], stream[i]};
    return v;
  endfunction

  task automatic model_reset();
    stream.delete();
    for (int k = 0; k < 3; k++) begin
      start_m[k] = 0; cnt_m[k] = 0; det_m[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic e, input logic dd);
    if (!r || c) begin
      model_reset();
    end else if (e) begin
      stream.push_back(dd);
      for (int k = 0; k < 3; k++) begin
        det_m[k] = ((stream.size() - start_m[k]) >= 4) && (window(k) == pat_m[k]);
        if (det_m[k] && cnt_m[k] < max_m[k]) cnt_m[k]++;
`ifdef SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN
        if (det_m[k]) start_m[k] = stream.size();
`endif
      end
      if (stream.size() > 16) begin
        void'(stream.pop_front());
        for (int k = 0; k < 3; k++) if (start_m[k] > 0) start_m[k]--;
      end
    end else begin
      for (int k = 0; k < 3; k++) det_m[k] = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".det0"},  32'(det0),  32'(det_m[0]));
    check_eq({tag, ".cnt0"},  32'(cnt0),  32'(cnt_m[0]));
    check_eq({tag, ".hist0"}, 32'(hist0), 32'(window(0)));
    check_eq({tag, ".det1"},  32'(det1),  32'(det_m[1]));
    check_eq({tag, ".cnt1"},  32'(cnt1),  32'(cnt_m[1]));
    check_eq({tag, ".hist1"}, 32'(hist1), 32'(window(1)));
    check_eq({tag, ".det2"},  32'(det2),  32'(det_m[2]));
    check_eq({tag, ".cnt2"},  32'(cnt2),  32'(cnt_m[2]));
    check_eq({tag, ".hist2"}, 32'(hist2), 32'(window(2)));
  endtask

  task automatic step(input string tag, input logic r, input logic c, input logic e, input logic dd);
    @(negedge clk);
    rst_n = r; clr = c; en = e; d = dd;
    @(posedge clk);
    #1;
    model_edge(r, c, e, dd);
    compare_all(tag);
  endtask

  task automatic do_reset();
    step("rst", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [6:0]  ovl_bits;
  logic [12:0] sat_bits;

  initial begin
    pat_m[0] = 4'b1011; max_m[0] = 255;
    pat_m[1] = 4'b0000; max_m[1] = 255;
    pat_m[2] = 4'b1011; max_m[2] = 3;
    model_reset();
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; d = 1'b0;
    #3;
    compare_all("rst_async");
    do_reset();
    do_reset();

    // Basic overlap: 1,0,1,1,0,1,1
    ovl_bits = 7'b1011011;
    for (int i = 6; i >= 0; i--) begin
      step("ovl", 1'b1, 1'b0, 1'b1, ovl_bits[i]);
      if (i == 3) check_eq("ovl_det4", 32'(det0), 32'd1);
    end
`ifdef SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN
    check_eq("ovl_det7", 32'(det0), 32'd0);
    check_eq("ovl_cnt", 32'(cnt0), 32'd1);
    check_eq("ovl_hist", 32'(hist0), 32'h3);
`else
    check_eq("ovl_det7", 32'(det0), 32'd1);
    check_eq("ovl_cnt", 32'(cnt0), 32'd2);
    check_eq("ovl_hist", 32'(hist0), 32'hb);
`endif

    // Enable gaps with toggling d between every enabled bit
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step("gap_off", 1'b1, 1'b0, 1'b0, ~ovl_bits[i]);
      check_eq("gap_det_off", 32'(det0), 32'd0);
      step("gap_on", 1'b1, 1'b0, 1'b1, ovl_bits[i]);
    end
`ifndef SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN
    check_eq("gap_cnt", 32'(cnt0), 32'd2);
`endif

    // Fill guard on the all-zero pattern instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("fill", 1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        check_eq("fill_det3", 32'(det1), 32'd0);
        check_eq("fill_cnt3", 32'(cnt1), 32'd0);
      end
      if (i == 3) begin
        check_eq("fill_det4", 32'(det1), 32'd1);
        check_eq("fill_cnt4", 32'(cnt1), 32'd1);
      end
    end
`ifndef SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN
    check_eq("fill_cnt5", 32'(cnt1), 32'd2);
`endif

    // Clear priority over enable, then a fresh match
    do_reset();
    step("clr_a", 1'b1, 1'b0, 1'b1, 1'b1);
    step("clr_b", 1'b1, 1'b0, 1'b1, 1'b0);
    step("clr_c", 1'b1, 1'b0, 1'b1, 1'b1);
    step("clr_en", 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("clr_hist", 32'(hist0), 32'd0);
    check_eq("clr_cnt", 32'(cnt0), 32'd0);
    check_eq("clr_det", 32'(det0), 32'd0);
    step("clr_d", 1'b1, 1'b0, 1'b1, 1'b1);
    step("clr_e", 1'b1, 1'b0, 1'b1, 1'b0);
    step("clr_f", 1'b1, 1'b0, 1'b1, 1'b1);
    step("clr_g", 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("clr_cnt_after", 32'(cnt0), 32'd1);

    // Asynchronous reset mid-stream: outputs zero before the next edge
    step("ar_a", 1'b1, 1'b0, 1'b1, 1'b0);
    step("ar_b", 1'b1, 1'b0, 1'b1, 1'b1);
    step("ar_c", 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("ar_async");
    check_eq("ar_cnt0", 32'(cnt0), 32'd0);
    check_eq("ar_hist0", 32'(hist0), 32'd0);
    do_reset();

    // Saturation on the 2-bit count instance
    sat_bits = 13'b1011011011011;
    for (int i = 12; i >= 0; i--) step("sat", 1'b1, 1'b0, 1'b1, sat_bits[i]);
`ifndef SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN
    check_eq("sat_cnt", 32'(cnt2), 32'd3);
    check_eq("sat_det", 32'(det2), 32'd1);
`endif

    // Randomized stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r, c, e, dd;
      r  = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 9) < 7);
      dd = 1'($urandom);
      step("rnd", r, c, e, dd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
- Consumes the serial bit stream produced by the lab's enabled D flip-flop stage. Inputs are en (shift enable) and d (data bit).
- Shifts each enabled bit into a PAT_LEN-bit history register.
- Flags a match of a parameterised pattern as a one-cycle registered pulse.
- Keeps a saturating count of matches. Used as the lab's next step from single storage elements to a sequential datapath.

Parameters:
- PAT_LEN, 4, number of bits in the pattern (≥2).
- PATTERN, 4'b1011, target pattern. The MSB is the oldest bit received; the LSB is the newest.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of history, fill level and count.
- en  input  1  sample enable; d is shifted in only when en=1.
- d  input  1  serial data bit.
- detect  output  1  registered one-cycle match pulse.
- count  output  CNT_W  saturating number of matches.
- hist  output  PAT_LEN  current history register, for debug and lab display.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hist=0, fill=0, detect=0, count=0 immediately.
  - All outputs hold these values while rst_n=0.
- Per rising clk edge, with priority clr > en:
  - clr=1: hist=0, fill=0, count=0, detect=0. en and d are ignored.
  - en=1:
    - hist_next = {hist[PAT_LEN-2:0], d}.
    - fill increments and saturates at PAT_LEN.
    - match = (hist_next == PATTERN) && (fill+1 ≥ PAT_LEN).
    - detect_next = match.
    - count increments on a match, saturating at all-ones (no wrap).
  - en=0: hist, fill and count hold; detect=0.
- Latency:
  - The bit that completes the pattern is sampled at edge k.
  - detect is high from edge k to edge k+1 only.
  - count shows the new value from edge k.
- Overlap (default): hist is not cleared on a match, so patterns may share bits. With 1011, the stream 1011011 produces two matches.
- Fill rule:
  - No detect until PAT_LEN enabled bits have arrived since reset or clr.
  - This prevents false matches against the zero-initialised history, e.g. when PATTERN=0000.
- Internal fill state: a counter 0..PAT_LEN of width $clog2(PAT_LEN+1). It functions as a small FSM: FILLING while fill<PAT_LEN, then ARMED.
- Reset mid-stream: the partial history is lost, and matching restarts from an empty fill.
- Simultaneous clr and en: clr wins and the incoming bit is discarded.
- Count at saturation with a new match: count stays all-ones and detect still pulses.

Optional Feature:
- Macro: SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN.
- Defined: on a match, hist_next is forced to 0 and fill_next to 0 (in place of the shifted value).
  - The next match therefore needs PAT_LEN fresh enabled bits.
  - detect and count still update for the current match.
- Undefined: overlapping detection as described above.

Decomposition:
- Package serial_pattern_pkg holds:
  - default constants DEF_PAT_LEN=4, DEF_PATTERN=4'b1011, DEF_CNT_W=8;
  - a function computing the fill counter width.
- Sub-module enabled_shift_reg:
  - an N-bit shift register with clk, rst_n, clr, en, d and parallel output q;
  - built as a chain of enabled D stages.
  - The detector instantiates it for hist and adds the fill/compare/count logic.

Test Plan (defaults unless noted; one enabled bit per cycle):
- Basic overlap:
  - Stimulus: reset, then d=1,0,1,1,0,1,1 with en=1.
  - Expected: detect pulses after the 4th and 7th bits; count=2; hist=1011 at the end.
- Enable gaps:
  - Stimulus: same stream, with en=0 cycles (d toggling) inserted between every bit.
  - Expected: identical detect sequence relative to enabled bits; detect=0 during en=0; count=2.
- Fill guard:
  - Stimulus: PATTERN=4'b0000; after reset send d=0,0,0.
  - Expected: detect=0, count=0. A 4th 0 gives detect=1, count=1; a 5th 0 gives count=2.
- Clear priority and reset mid-stream:
  - Stimulus 1: send 1,0,1, then clr=1 with en=1 and d=1.
    - Expected: hist=0, count=0, no detect; sending 1,0,1,1 then gives count=1.
  - Stimulus 2: drop rst_n mid-stream.
    - Expected: outputs zero asynchronously, before the next clk edge.
- Saturation:
  - Stimulus: CNT_W=2; send 1011 repeated via overlap ("1011011011011", 4 matches).
  - Expected: count goes 1,2,3,3; detect still pulses on the 4th match.
- Non-overlap build:
  - Stimulus: define SERIAL_PATTERN_DETECTOR_NONOVERLAP_EN; send 1,0,1,1,0,1,1.
  - Expected: a single detect after the 4th bit; count=1; hist=0011 at the end.
